// File: rtl/motor_pkg.sv
// Motor-drive shared definitions: command codes, scheduler states, direction patterns.
// Latency: none (package only).
// Backpressure: n/a.
package motor_pkg;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_RIGHT = 2'b10,
        CMD_LEFT  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_RAMP = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    // H-bridge pin pattern {a_fwd, a_rev, b_fwd, b_rev} for a command.
    function automatic logic [3:0] dir_pattern(input logic [1:0] cmd);
        logic [3:0] pat;
        case (cmd)
            CMD_FWD:   pat = 4'b1010;
            CMD_RIGHT: pat = 4'b1001;
            CMD_LEFT:  pat = 4'b0110;
            default:   pat = 4'b0000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// 8-bit PWM generator: free-running counter compared against a duty value.
// Latency: o_pwm is combinational from i_duty and the counter (no extra register).
// Backpressure: none; runs every clock.
// Ports: clk, rst_n (async active-low), i_duty[7:0] (0 = off, 255 = 255/256 on), o_pwm.
module pwm_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_duty,
    output logic       o_pwm
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;  // wraps 255 -> 0
        end
    end

    // Strict compare: duty 0 never drives, duty 255 drives 255 of 256 counts.
    assign o_pwm = (i_duty > r_cnt);

endmodule

// File: rtl/motor_sched.sv
// Motor scheduler: arbitrates line-follow vs override, dead-time brake on direction change, soft-start duty ramp, gated PWM pins.
// Latency: grants/command registered 1 cycle after requests; motor pins registered 1 cycle after state/PWM.
// Backpressure: none; requesters are never stalled, newest command wins, busy flags DEAD/RAMP.
// Ports: clk, rst_n; req_lf/cmd_lf (low prio), req_ov/cmd_ov (high prio), duty_target[7:0];
//        gnt_lf, gnt_ov, motor[3:0] {a_fwd,a_rev,b_fwd,b_rev}, busy, state_o[1:0].
module motor_sched
    import motor_pkg::*;
#(
    parameter int DEAD_CYCLES = 16,
    parameter int RAMP_DIV    = 256,
    parameter int RAMP_STEP   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_lf,
    input  logic [1:0] cmd_lf,
    input  logic       req_ov,
    input  logic [1:0] cmd_ov,
    input  logic [7:0] duty_target,
    output logic       gnt_lf,
    output logic       gnt_ov,
    output logic [3:0] motor,
    output logic       busy,
    output logic [1:0] state_o
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [8:0]    STEP9     = 9'(RAMP_STEP);

    state_e        r_state, w_state_nxt;
    logic [1:0]    r_cmd_q, r_cmd_act, w_act_nxt;
    logic [7:0]    r_duty, w_duty_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [DW-1:0] r_dead, w_dead_nxt;
    logic          r_gnt_lf, r_gnt_ov;
    logic [3:0]    r_motor, w_motor_nxt;

    logic          w_pwm;
    logic [1:0]    w_eff_cmd;
    logic [8:0]    w_up_sum, w_dn_lim;
    logic [7:0]    w_duty_up, w_duty_dn;

    pwm_gen u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_duty (r_duty),
        .o_pwm  (w_pwm)
    );

    // Override wins; nobody requesting means STOP.
    assign w_eff_cmd = req_ov ? cmd_ov : (req_lf ? cmd_lf : CMD_STOP);

    // Ramp steps evaluated at 9 bits so neither direction wraps past the target.
    assign w_up_sum  = {1'b0, r_duty} + STEP9;
    assign w_dn_lim  = {1'b0, duty_target} + STEP9;
    assign w_duty_up = (w_up_sum > {1'b0, duty_target}) ? duty_target : w_up_sum[7:0];
    assign w_duty_dn = ({1'b0, r_duty} >= w_dn_lim) ? (r_duty - STEP9[7:0]) : duty_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cmd_q   <= CMD_STOP;
            r_cmd_act <= CMD_STOP;
            r_duty    <= 8'd0;
            r_presc   <= '0;
            r_dead    <= '0;
            r_gnt_lf  <= 1'b0;
            r_gnt_ov  <= 1'b0;
            r_motor   <= 4'b0000;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd_q   <= w_eff_cmd;
            r_cmd_act <= w_act_nxt;
            r_duty    <= w_duty_nxt;
            r_presc   <= w_presc_nxt;
            r_dead    <= w_dead_nxt;
            r_gnt_lf  <= req_lf & ~req_ov;
            r_gnt_ov  <= req_ov;
            r_motor   <= w_motor_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_act_nxt   = r_cmd_act;
        w_duty_nxt  = r_duty;
        w_presc_nxt = r_presc;
        w_dead_nxt  = r_dead;
        w_motor_nxt = ((r_state == ST_RAMP) || (r_state == ST_RUN))
                    ? (dir_pattern(r_cmd_act) & {4{w_pwm}}) : 4'b0000;

        case (r_state)
            ST_IDLE: begin
                // From rest there is nothing to brake, so go straight to the ramp.
                if (r_cmd_q != CMD_STOP) begin
                    w_state_nxt = ST_RAMP;
                    w_act_nxt   = r_cmd_q;
                    w_duty_nxt  = 8'd0;
                    w_presc_nxt = '0;
                end
            end
            ST_RAMP: begin
                if (r_cmd_q != r_cmd_act) begin
                    w_state_nxt = ST_DEAD;
                    w_dead_nxt  = DEAD_LOAD;
                end else if (r_duty == duty_target) begin
                    w_state_nxt = ST_RUN;
                end else if (r_presc == PRESC_MAX) begin
                    w_presc_nxt = '0;
                    w_duty_nxt  = (r_duty < duty_target) ? w_duty_up : w_duty_dn;
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            ST_RUN: begin
                if (r_cmd_q != r_cmd_act) begin
                    w_state_nxt = ST_DEAD;
                    w_dead_nxt  = DEAD_LOAD;
                end else if (duty_target != r_duty) begin
                    w_state_nxt = ST_RAMP;
                    w_presc_nxt = '0;
                end
            end
            ST_DEAD: begin
                w_duty_nxt = 8'd0;
                // The full brake always runs out; only the command seen at expiry matters.
                if (r_dead == '0) begin
                    if (r_cmd_q == CMD_STOP) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RAMP;
                        w_act_nxt   = r_cmd_q;
                        w_presc_nxt = '0;
                    end
                end else begin
                    w_dead_nxt = r_dead - DW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign gnt_lf  = r_gnt_lf;
    assign gnt_ov  = r_gnt_ov;
    assign motor   = r_motor;
    assign busy    = (r_state == ST_DEAD) || (r_state == ST_RAMP);
    assign state_o = r_state;

endmodule

// File: tb/tb_motor_sched.sv
// Bench for motor_sched: directed scenarios plus random command traffic against a cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_motor_sched;

    localparam int DEAD = 4;
    localparam int DIV  = 4;
    localparam int STEP = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_lf, req_ov;
    logic [1:0] cmd_lf, cmd_ov;
    logic [7:0] duty_target;
    logic       gnt_lf, gnt_ov, busy;
    logic [3:0] motor;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference state: mode 0 idle, 1 braking, 2 ramping, 3 running.
    int m_mode, m_act, m_duty, m_presc, m_dead, m_cmdq, m_glf, m_gov, m_cnt, m_motor;
    int pat [4] = '{0, 10, 9, 6};

    motor_sched #(.DEAD_CYCLES(DEAD), .RAMP_DIV(DIV), .RAMP_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_lf(req_lf), .cmd_lf(cmd_lf), .req_ov(req_ov), .cmd_ov(cmd_ov),
        .duty_target(duty_target),
        .gnt_lf(gnt_lf), .gnt_ov(gnt_ov), .motor(motor), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_act = 0; m_duty = 0; m_presc = 0; m_dead = 0;
        m_cmdq = 0; m_glf = 0; m_gov = 0; m_cnt = 0; m_motor = 0;
    endtask

    task automatic model_step();
        int eff, tgt, nmot;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tgt  = int'(duty_target);
        nmot = ((m_mode == 2 || m_mode == 3) && m_duty > m_cnt) ? pat[m_act] : 0;
        eff  = req_ov ? int'(cmd_ov) : (req_lf ? int'(cmd_lf) : 0);
        case (m_mode)
            0: if (m_cmdq != 0) begin
                m_mode = 2; m_act = m_cmdq; m_duty = 0; m_presc = 0;
            end
            2: begin
                if (m_cmdq != m_act) begin
                    m_mode = 1; m_dead = DEAD - 1;
                end else if (m_duty == tgt) begin
                    m_mode = 3;
                end else if (m_presc == DIV - 1) begin
                    m_presc = 0;
                    if (m_duty < tgt) m_duty = (m_duty + STEP > tgt) ? tgt : m_duty + STEP;
                    else              m_duty = (m_duty - STEP < tgt) ? tgt : m_duty - STEP;
                end else begin
                    m_presc++;
                end
            end
            3: begin
                if (m_cmdq != m_act) begin
                    m_mode = 1; m_dead = DEAD - 1;
                end else if (tgt != m_duty) begin
                    m_mode = 2; m_presc = 0;
                end
            end
            default: begin
                m_duty = 0;
                if (m_dead == 0) begin
                    if (m_cmdq == 0) m_mode = 0;
                    else begin m_mode = 2; m_act = m_cmdq; m_presc = 0; end
                end else begin
                    m_dead--;
                end
            end
        endcase
        m_cmdq  = eff;
        m_gov   = req_ov ? 1 : 0;
        m_glf   = (req_lf && !req_ov) ? 1 : 0;
        m_cnt   = (m_cnt + 1) % 256;
        m_motor = nmot;
    endtask

    task automatic check_all();
        check_eq("gnt_lf", int'(gnt_lf), m_glf);
        check_eq("gnt_ov", int'(gnt_ov), m_gov);
        check_eq("motor", int'(motor), m_motor);
        check_eq("state", int'(state_o), m_mode);
        check_eq("busy", int'(busy), (m_mode == 1 || m_mode == 2) ? 1 : 0);
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Run n cycles, counting observed brake cycles and cycles with any pin driven.
    task automatic run(input int n, output int dead_n, output int hi_n);
        dead_n = 0; hi_n = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (state_o == 2'd1 && busy) dead_n++;
            if (motor != 4'b0000) hi_n++;
        end
    endtask

    task automatic set_lf(input logic r, input logic [1:0] c);
        req_lf = r; cmd_lf = c;
    endtask

    int d, h, k;

    initial begin
        rst_n = 1'b0; req_lf = 0; req_ov = 0; cmd_lf = 0; cmd_ov = 0; duty_target = 0;
        model_reset();
        #1;
        check_eq("reset_motor", int'(motor), 0);
        check_eq("reset_gnt", int'({gnt_lf, gnt_ov}), 0);
        check_eq("reset_state", int'(state_o), 0);
        run(3, d, h);
        rst_n = 1'b1;

        // Idle with no requests.
        run(20, d, h);
        check_eq("idle_motor_hi", h, 0);

        // Soft start to FWD at 200.
        set_lf(1, 2'd1); duty_target = 8'd200;
        cycle();
        check_eq("soft_gnt_lf", int'(gnt_lf), 1);
        run(40, d, h);
        check_eq("soft_run_state", int'(state_o), 3);
        run(256, d, h);
        check_eq("soft_high_time", h, 200);

        // Reversal FWD -> LEFT.
        set_lf(1, 2'd3);
        run(60, d, h);
        check_eq("rev_dead_len", d, DEAD);
        check_eq("rev_run_state", int'(state_o), 3);

        // Drop everything, then both requests in the same cycle.
        set_lf(0, 2'd0);
        run(20, d, h);
        check_eq("stop_idle", int'(state_o), 0);
        set_lf(1, 2'd1); req_ov = 1; cmd_ov = 2'd2;
        cycle();
        check_eq("prio_gnt_ov", int'(gnt_ov), 1);
        check_eq("prio_gnt_lf", int'(gnt_lf), 0);
        run(40, d, h);
        req_ov = 0;
        run(50, d, h);
        check_eq("prio_drop_dead", d, DEAD);
        check_eq("prio_drop_gnt_lf", int'(gnt_lf), 1);

        // STOP while ramping.
        set_lf(0, 2'd0);
        run(20, d, h);
        set_lf(1, 2'd1); duty_target = 8'd255;
        run(8, d, h);
        check_eq("abort_in_ramp", int'(state_o), 2);
        set_lf(1, 2'd0);
        run(12, d, h);
        check_eq("abort_dead_len", d, DEAD);
        check_eq("abort_idle", int'(state_o), 0);

        // Toggle FWD -> RIGHT -> FWD: brake still runs its full length.
        set_lf(1, 2'd1);
        run(40, d, h);
        set_lf(1, 2'd2); cycle();
        set_lf(1, 2'd1);
        run(40, d, h);
        check_eq("toggle_dead_len", d, DEAD);
        check_eq("toggle_run", int'(state_o), 3);

        // Asynchronous reset between edges while pins are driven.
        k = 0;
        while (motor == 4'b0000 && k < 300) begin cycle(); k++; end
        check_eq("async_setup_driven", (motor != 4'b0000) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_motor", int'(motor), 0);
        check_eq("async_gnt", int'({gnt_lf, gnt_ov}), 0);
        check_eq("async_state", int'(state_o), 0);
        model_reset();
        set_lf(0, 2'd0);
        run(2, d, h);
        rst_n = 1'b1;
        run(10, d, h);
        check_eq("async_release_idle", int'(state_o), 0);

        // Random traffic.
        for (int s = 0; s < 150; s++) begin
            int sel;
            req_lf = 1'($urandom_range(0, 1));
            req_ov = ($urandom_range(0, 3) == 0);
            cmd_lf = 2'($urandom_range(0, 3));
            cmd_ov = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            case (sel)
                0: duty_target = 8'd0;
                1: duty_target = 8'd255;
                2: duty_target = 8'd64;
                3: duty_target = 8'd100;
                default: duty_target = 8'($urandom_range(0, 255));
            endcase
            run($urandom_range(1, 30), d, h);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
